// File: rtl/fnd_scan_scheduler_if.sv
// Handshake and display-drive bundle for fnd_scan_scheduler.
// master = producer/observer side, slave = scheduler side.
interface fnd_scan_scheduler_if;
    logic        i_disp_on;
    logic [15:0] i_value;
    logic        i_valid;
    logic        o_ready;
    logic        o_en;
    logic [1:0]  o_select;
    logic [3:0]  o_fnd_data;
    logic        o_frame_done;

    modport master (
        output i_disp_on, i_value, i_valid,
        input  o_ready, o_en, o_select, o_fnd_data, o_frame_done
    );

    modport slave (
        input  i_disp_on, i_value, i_valid,
        output o_ready, o_en, o_select, o_fnd_data, o_frame_done
    );
endinterface

// File: rtl/fnd_scan_scheduler.sv
// Four-digit FND scan scheduler: SHOW/BLANK multiplexing with a one-deep pending value slot.
// Optional macro FND_LEADING_ZERO_BLANK_EN suppresses leading-zero digits 3..1.
module fnd_scan_scheduler #(
    parameter int unsigned SCAN_DIV  = 3000,
    parameter int unsigned BLANK_CYC = 16
) (
    input logic                  i_clk,
    input logic                  i_reset_n,
    fnd_scan_scheduler_if.slave  bus
);

    localparam logic [15:0] SHOW_LAST  = 16'(SCAN_DIV - 1);
    localparam logic [15:0] BLANK_LAST = 16'(BLANK_CYC - 1);

    typedef enum logic [1:0] {StOff, StShow, StBlank} state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [3:0]  hold_q, hold_d;
    logic [15:0] disp_q;
    logic [15:0] pend_q;
    logic        full_q;
    logic [1:0]  sync_q;
    logic        rst_int_n;
    logic [3:0]  cur_nib;
    logic        lead_ok;
    logic        frame_done;
    logic        accept;
    logic        commit;

    // Assertion is immediate via the async clear; release takes two edges.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = sync_q[1];

    always_comb begin
        cur_nib = 4'h0;
        unique case (idx_q)
            2'd0: cur_nib = disp_q[3:0];
            2'd1: cur_nib = disp_q[7:4];
            2'd2: cur_nib = disp_q[11:8];
            2'd3: cur_nib = disp_q[15:12];
            default: cur_nib = 4'h0;
        endcase
    end

`ifdef FND_LEADING_ZERO_BLANK_EN
    always_comb begin
        lead_ok = 1'b1;
        unique case (idx_q)
            2'd0: lead_ok = 1'b1;
            2'd1: lead_ok = (disp_q[15:4] != 12'h000);
            2'd2: lead_ok = (disp_q[15:8] != 8'h00);
            2'd3: lead_ok = (disp_q[15:12] != 4'h0);
            default: lead_ok = 1'b1;
        endcase
    end
`else
    assign lead_ok = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        unique case (state_q)
            StOff: begin
                cnt_d = 16'd0;
                idx_d = 2'd0;
                if (bus.i_disp_on) begin
                    state_d = StShow;
                end
            end
            StShow: begin
                hold_d = cur_nib;
                if (cnt_q == SHOW_LAST) begin
                    cnt_d   = 16'd0;
                    state_d = StBlank;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StBlank: begin
                if (cnt_q == BLANK_LAST) begin
                    cnt_d   = 16'd0;
                    idx_d   = idx_q + 2'd1;
                    state_d = StShow;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = StOff;
                cnt_d   = 16'd0;
                idx_d   = 2'd0;
            end
        endcase
        if (!bus.i_disp_on) begin
            state_d = StOff;
            cnt_d   = 16'd0;
            idx_d   = 2'd0;
        end
    end

    always_ff @(posedge i_clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q <= StOff;
            cnt_q   <= 16'd0;
            idx_q   <= 2'd0;
            hold_q  <= 4'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
        end
    end

    assign frame_done = (state_q == StShow) && (idx_q == 2'd3) && (cnt_q == SHOW_LAST);
    assign accept     = bus.i_valid && !full_q;
    // A full slot is flushed at frame end, or immediately while idle.
    assign commit     = full_q && (frame_done || (state_q == StOff));

    always_ff @(posedge i_clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            disp_q <= 16'h0000;
            pend_q <= 16'h0000;
            full_q <= 1'b0;
        end else begin
            if (commit) begin
                disp_q <= pend_q;
                full_q <= 1'b0;
            end else if (accept) begin
                pend_q <= bus.i_value;
                full_q <= 1'b1;
            end
        end
    end

    always_comb begin
        bus.o_en       = 1'b0;
        bus.o_select   = idx_q;
        bus.o_fnd_data = 4'h0;
        unique case (state_q)
            StShow: begin
                bus.o_en       = lead_ok;
                bus.o_fnd_data = cur_nib;
            end
            StBlank: begin
                bus.o_fnd_data = hold_q;
            end
            default: begin
                bus.o_select = 2'd0;
            end
        endcase
    end

    assign bus.o_frame_done = frame_done;
    assign bus.o_ready      = ~full_q;

endmodule

// File: tb/tb_fnd_scan_scheduler.sv
// Randomized bench for fnd_scan_scheduler against a frame-position reference model.
module tb_fnd_scan_scheduler;

    localparam int SD    = 4;
    localparam int BC    = 2;
    localparam int SLOT  = SD + BC;
    localparam int FRAME = 4 * SLOT;

    logic clk;
    logic rst_n;

    fnd_scan_scheduler_if bus ();

    fnd_scan_scheduler #(
        .SCAN_DIV  (SD),
        .BLANK_CYC (BC)
    ) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: on/off, cycles since scanning began, register contents.
    bit          m_on;
    int          m_t;
    logic [15:0] m_disp;
    logic [15:0] m_pend;
    bit          m_full;
    logic [3:0]  m_last;
    int          off_left;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit lead_en(input int d, input logic [15:0] v);
`ifdef FND_LEADING_ZERO_BLANK_EN
        if (d == 0) return 1'b1;
        return (v >> (4 * d)) != 16'h0000;
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_reset();
        m_on   = 1'b0;
        m_t    = 0;
        m_disp = 16'h0000;
        m_pend = 16'h0000;
        m_full = 1'b0;
        m_last = 4'h0;
    endtask

    task automatic drive(input bit idle);
        int r;
        if (idle) begin
            bus.i_disp_on = 1'b0;
            bus.i_valid   = 1'b0;
        end else begin
            if (off_left > 0) begin
                bus.i_disp_on = 1'b0;
                off_left--;
            end else if ($urandom_range(0, 149) == 0) begin
                bus.i_disp_on = 1'b0;
                off_left = $urandom_range(1, 6);
            end else begin
                bus.i_disp_on = 1'b1;
            end
            bus.i_valid = ($urandom_range(0, 5) == 0);
            r = $urandom_range(0, 7);
            case (r)
                0: bus.i_value = 16'h0000;
                1: bus.i_value = 16'h0050;
                2: bus.i_value = 16'h0005;
                3: bus.i_value = 16'($urandom_range(0, 15));
                4: bus.i_value = 16'h12AB;
                default: bus.i_value = 16'($urandom);
            endcase
        end
    endtask

    // One clock: drive after the rising edge, check and advance the model at the falling edge.
    task automatic run_cycle(input bit idle);
        int p, d, ph;
        bit show, e_en, e_fd, acc, com;
        logic [3:0] nib, e_data;
        logic [1:0] e_sel;
        @(posedge clk);
        #1;
        drive(idle);
        @(negedge clk);
        p = m_t % FRAME;
        d = p / SLOT;
        ph = p % SLOT;
        show = m_on && (ph < SD);
        nib = 4'((m_disp >> (4 * d)) & 16'hF);
        if (!m_on) begin
            e_en = 0; e_sel = 0; e_data = 0; e_fd = 0;
        end else if (show) begin
            e_en = lead_en(d, m_disp); e_sel = 2'(d); e_data = nib;
            e_fd = (d == 3) && (ph == SD - 1);
        end else begin
            e_en = 0; e_sel = 2'(d); e_data = m_last; e_fd = 0;
        end
        check_eq("en", bus.o_en, e_en);
        check_eq("select", bus.o_select, e_sel);
        check_eq("fnd_data", bus.o_fnd_data, e_data);
        check_eq("frame_done", bus.o_frame_done, e_fd);
        check_eq("ready", bus.o_ready, !m_full);
        if (show) m_last = nib;
        acc = bus.i_valid && !m_full;
        com = m_full && (!m_on || e_fd);
        if (com) begin
            m_disp = m_pend;
            m_full = 1'b0;
        end else if (acc) begin
            m_pend = bus.i_value;
            m_full = 1'b1;
        end
        if (!bus.i_disp_on) begin
            m_on = 1'b0; m_t = 0;
        end else if (!m_on) begin
            m_on = 1'b1; m_t = 0;
        end else begin
            m_t++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_en"}, bus.o_en, 0);
        check_eq({tag, "_select"}, bus.o_select, 0);
        check_eq({tag, "_data"}, bus.o_fnd_data, 0);
        check_eq({tag, "_frame_done"}, bus.o_frame_done, 0);
        check_eq({tag, "_ready"}, bus.o_ready, 1);
    endtask

    initial begin
        bit found;
        rst_n = 1'b0;
        bus.i_disp_on = 1'b0;
        bus.i_valid   = 1'b0;
        bus.i_value   = 16'h0000;
        off_left = 0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("por");
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) run_cycle(1'b1);
        repeat (1500) run_cycle(1'b0);

        // Async reset while a digit is being shown.
        found = 1'b0;
        off_left = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            run_cycle(1'b0);
            if (bus.o_en) found = 1'b1;
        end
        check_eq("reach_show", found, 1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("held_rst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        repeat (4) run_cycle(1'b1);
        repeat (1500) run_cycle(1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
